// File: rtl/t5_pkg.sv
// Shared constants for the T5 register block: data width, write-back source codes, sweep FSM states.
package t5_pkg;

  localparam int T5_XLEN = 32;

  localparam logic [1:0] T5_WB_ALU  = 2'd0;
  localparam logic [1:0] T5_WB_DWB  = 2'd1;
  localparam logic [1:0] T5_WB_PC   = 2'd2;
  localparam logic [1:0] T5_WB_ZERO = 2'd3;

  localparam logic [0:0] T5_CLR = 1'b0;
  localparam logic [0:0] T5_RUN = 1'b1;

endpackage

// File: rtl/t5_regs_mt_if.sv
// Read/write-back bus between the pipeline (master) and the multi-hart register block (slave).
interface t5_regs_mt_if #(
  parameter int XLEN = t5_pkg::T5_XLEN,
  parameter int HW   = 2
);
  logic            sena;
  logic [HW-1:0]   fhart;
  logic [4:0]      rs1a;
  logic [4:0]      rs2a;
  logic [XLEN-1:0] rs1d;
  logic [XLEN-1:0] rs2d;
  logic [HW-1:0]   mhart;
  logic            mwre;
  logic [1:0]      msel;
  logic [4:0]      rd0a;
  logic [XLEN-1:0] malu;
  logic [XLEN-1:0] dwb_dti;
  logic [XLEN-1:0] mpc;
  logic            busy;

  modport master (
    output sena, fhart, rs1a, rs2a, mhart, mwre, msel, rd0a, malu, dwb_dti, mpc,
    input  rs1d, rs2d, busy
  );

  modport slave (
    input  sena, fhart, rs1a, rs2a, mhart, mwre, msel, rd0a, malu, dwb_dti, mpc,
    output rs1d, rs2d, busy
  );
endinterface

// File: rtl/t5_gprf_ram.sv
// Flat GPR storage: one write port, two registered read ports (read-first), no reset on the array.
module t5_gprf_ram #(
  parameter int XLEN = t5_pkg::T5_XLEN,
  parameter int AW   = 7
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            re,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);
  localparam int DEPTH = 2 ** AW;

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
    if (re) begin
      rd1 <= mem[ra1];
      rd2 <= mem[ra2];
    end
  end
endmodule

// File: rtl/t5_regs_mt.sv
// Multi-hart GPR block: post-reset clear sweep, write-back source mux, x0/range masking.
// Define T5_REGS_BYPASS_EN for write-first read ports (default build is read-first).
module t5_regs_mt
  import t5_pkg::*;
#(
  parameter int XLEN = T5_XLEN,
  parameter int HW   = 2,
  parameter int NREG = 32
) (
  input  logic        sclk,
  input  logic        srstn,
  t5_regs_mt_if.slave bus
);
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int FW = HW + AW;
  localparam logic [FW-1:0] SWEEP_LAST = '1;

  logic [0:0]      state_reg, state_next;
  logic [FW-1:0]   sweep_idx_reg, sweep_idx_next;
  logic            run;
  logic [XLEN-1:0] wb_data;
  logic            wr_addr_ok;
  logic            wr_en;
  logic            ram_we;
  logic            ram_re;
  logic [FW-1:0]   ram_wa;
  logic [XLEN-1:0] ram_wd;
  logic [4:0]      rs_addr [2];
  logic [FW-1:0]   ram_ra  [2];
  logic [XLEN-1:0] ram_q   [2];
  logic [XLEN-1:0] rd_data [2];

  always_comb begin
    state_next     = state_reg;
    sweep_idx_next = sweep_idx_reg;
    if (state_reg == T5_CLR) begin
      sweep_idx_next = sweep_idx_reg + 1'b1;
      if (sweep_idx_reg == SWEEP_LAST) begin
        state_next = T5_RUN;
      end
    end
  end

  always_ff @(posedge sclk or negedge srstn) begin
    if (!srstn) begin
      state_reg     <= T5_CLR;
      sweep_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_idx_reg <= sweep_idx_next;
    end
  end

  assign run      = (state_reg == T5_RUN);
  assign bus.busy = !run;

  always_comb begin
    case (bus.msel)
      T5_WB_ALU: wb_data = bus.malu;
      T5_WB_DWB: wb_data = bus.dwb_dti;
      T5_WB_PC:  wb_data = bus.mpc;
      default:   wb_data = '0;
    endcase
  end

  // Addresses beyond NREG and x0 never reach the array.
  assign wr_addr_ok = ((bus.rd0a >> AW) == 5'd0) && (bus.rd0a[AW-1:0] != '0);
  assign wr_en      = run && bus.sena && bus.mwre && wr_addr_ok;

  // While clearing, the sweep owns the write port and write-back requests are dropped.
  assign ram_we = !run || wr_en;
  assign ram_wa = run ? {bus.mhart, bus.rd0a[AW-1:0]} : sweep_idx_reg;
  assign ram_wd = run ? wb_data : '0;
  assign ram_re = run && bus.sena;

  assign rs_addr[0] = bus.rs1a;
  assign rs_addr[1] = bus.rs2a;

  t5_gprf_ram #(
    .XLEN (XLEN),
    .AW   (FW)
  ) u_ram (
    .clk (sclk),
    .we  (ram_we),
    .wa  (ram_wa),
    .wd  (ram_wd),
    .re  (ram_re),
    .ra1 (ram_ra[0]),
    .ra2 (ram_ra[1]),
    .rd1 (ram_q[0]),
    .rd2 (ram_q[1])
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic addr_zero;
      logic zero_reg;

      assign ram_ra[gi] = {bus.fhart, rs_addr[gi][AW-1:0]};
      assign addr_zero  = ((rs_addr[gi] >> AW) != 5'd0) || (rs_addr[gi][AW-1:0] == '0);

      // Output masking is tracked in a flop beside the RAM data so the port stays fully registered.
      always_ff @(posedge sclk or negedge srstn) begin
        if (!srstn) begin
          zero_reg <= 1'b1;
        end else if (!run) begin
          zero_reg <= 1'b1;
        end else if (bus.sena) begin
          zero_reg <= addr_zero;
        end
      end

`ifdef T5_REGS_BYPASS_EN
      logic            byp_reg;
      logic [XLEN-1:0] byp_data_reg;

      always_ff @(posedge sclk or negedge srstn) begin
        if (!srstn) begin
          byp_reg      <= 1'b0;
          byp_data_reg <= '0;
        end else if (run && bus.sena) begin
          byp_reg      <= wr_en && (bus.mhart == bus.fhart) && (bus.rd0a == rs_addr[gi]);
          byp_data_reg <= wb_data;
        end
      end

      assign rd_data[gi] = zero_reg ? '0 : (byp_reg ? byp_data_reg : ram_q[gi]);
`else
      assign rd_data[gi] = zero_reg ? '0 : ram_q[gi];
`endif
    end
  endgenerate

  assign bus.rs1d = rd_data[0];
  assign bus.rs2d = rd_data[1];
endmodule

// File: tb/tb_t5_regs_mt.sv
// Directed bench for t5_regs_mt: clear sweep, write/read, x0, source select, hazard, stall, reset restart.
module tb_t5_regs_mt;
  import t5_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

`ifdef T5_REGS_BYPASS_EN
  localparam logic [31:0] HZ_EXP = 32'h22;
`else
  localparam logic [31:0] HZ_EXP = 32'h11;
`endif

  t5_regs_mt_if #(.XLEN(32), .HW(2)) bus ();

  t5_regs_mt #(.XLEN(32), .HW(2), .NREG(32)) dut (
    .sclk  (clk),
    .srstn (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [1:0] h, input logic [4:0] r, input logic [1:0] sel,
                    input logic [31:0] alu, input logic [31:0] dwb, input logic [31:0] pc);
    bus.sena = 1'b1; bus.mwre = 1'b1; bus.mhart = h; bus.rd0a = r; bus.msel = sel;
    bus.malu = alu; bus.dwb_dti = dwb; bus.mpc = pc;
    step();
    bus.mwre = 1'b0;
    $display("write hart=%0d r%0d sel=%0d alu=%h dwb=%h pc=%h", h, r, sel, alu, dwb, pc);
  endtask

  task automatic rd(input logic [1:0] h, input logic [4:0] a1, input logic [4:0] a2);
    bus.sena = 1'b1; bus.fhart = h; bus.rs1a = a1; bus.rs2a = a2;
    step();
    $display("read  hart=%0d r%0d=%h r%0d=%h busy=%0b", h, a1, bus.rs1d, a2, bus.rs2d, bus.busy);
  endtask

  task automatic test_reset();
    int  cnt;
    bit  held_zero;
    rst_n = 1'b0;
    bus.sena = 1'b1; bus.fhart = 2'd2; bus.rs1a = 5'd5; bus.rs2a = 5'd9;
    bus.mwre = 1'b1; bus.mhart = 2'd2; bus.rd0a = 5'd5; bus.msel = T5_WB_ALU;
    bus.malu = 32'hFFFF_FFFF; bus.dwb_dti = 32'hFFFF_FFFF; bus.mpc = 32'hFFFF_FFFF;
    repeat (3) step();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
    total++; if (bus.rs1d !== 32'h0) begin bad++; $display("FAIL reset_rs1d: got %h want 0", bus.rs1d); end
    total++; if (bus.rs2d !== 32'h0) begin bad++; $display("FAIL reset_rs2d: got %h want 0", bus.rs2d); end
    rst_n = 1'b1;
    cnt = 0;
    held_zero = 1'b1;
    while (bus.busy === 1'b1 && cnt < 400) begin
      step();
      cnt++;
      if (bus.busy === 1'b1 && (bus.rs1d !== 32'h0 || bus.rs2d !== 32'h0)) held_zero = 1'b0;
    end
    bus.mwre = 1'b0;
    $display("sweep done after %0d cycles", cnt);
    total++; if (cnt != 128) begin bad++; $display("FAIL sweep_len: got %0d want 128", cnt); end
    total++; if (held_zero !== 1'b1) begin bad++; $display("FAIL sweep_read_hold: got %b want 1", held_zero); end
    rd(2'd2, 5'd5, 5'd31);
    total++; if (bus.rs1d !== 32'h0) begin bad++; $display("FAIL post_sweep_r5: got %h want 0", bus.rs1d); end
    total++; if (bus.rs2d !== 32'h0) begin bad++; $display("FAIL post_sweep_r31: got %h want 0", bus.rs2d); end
  endtask

  task automatic test_basic();
    wb(2'd2, 5'd5, T5_WB_ALU, 32'hDEAD_BEEF, 32'h0, 32'h0);
    rd(2'd2, 5'd5, 5'd0);
    total++; if (bus.rs1d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL basic_rs1: got %h want deadbeef", bus.rs1d); end
    total++; if (bus.rs2d !== 32'h0) begin bad++; $display("FAIL basic_x0: got %h want 0", bus.rs2d); end
    rd(2'd1, 5'd5, 5'd5);
    total++; if (bus.rs1d !== 32'h0) begin bad++; $display("FAIL basic_other_hart: got %h want 0", bus.rs1d); end
    rd(2'd2, 5'd0, 5'd5);
    total++; if (bus.rs2d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL basic_rs2: got %h want deadbeef", bus.rs2d); end
  endtask

  task automatic test_x0_src();
    wb(2'd2, 5'd0, T5_WB_ALU, 32'h0000_1234, 32'h0, 32'h0);
    wb(2'd2, 5'd10, T5_WB_DWB, 32'h1111_1111, 32'hA5A5_A5A5, 32'h2222_2222);
    wb(2'd2, 5'd11, T5_WB_PC, 32'h3333_3333, 32'h4444_4444, 32'h0000_0104);
    wb(2'd2, 5'd5, T5_WB_ZERO, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777);
    rd(2'd2, 5'd0, 5'd5);
    total++; if (bus.rs1d !== 32'h0) begin bad++; $display("FAIL x0_write: got %h want 0", bus.rs1d); end
    total++; if (bus.rs2d !== 32'h0) begin bad++; $display("FAIL sel_zero: got %h want 0", bus.rs2d); end
    rd(2'd2, 5'd10, 5'd11);
    total++; if (bus.rs1d !== 32'hA5A5_A5A5) begin bad++; $display("FAIL sel_dwb: got %h want a5a5a5a5", bus.rs1d); end
    total++; if (bus.rs2d !== 32'h0000_0104) begin bad++; $display("FAIL sel_pc: got %h want 00000104", bus.rs2d); end
  endtask

  task automatic test_harts();
    wb(2'd0, 5'd3, T5_WB_ALU, 32'h0000_0100, 32'h0, 32'h0);
    wb(2'd3, 5'd3, T5_WB_ALU, 32'h0000_0300, 32'h0, 32'h0);
    wb(2'd1, 5'd31, T5_WB_ALU, 32'hCAFE_0031, 32'h0, 32'h0);
    rd(2'd0, 5'd3, 5'd31);
    total++; if (bus.rs1d !== 32'h100) begin bad++; $display("FAIL hart0_r3: got %h want 00000100", bus.rs1d); end
    total++; if (bus.rs2d !== 32'h0) begin bad++; $display("FAIL hart0_r31: got %h want 0", bus.rs2d); end
    rd(2'd3, 5'd3, 5'd3);
    total++; if (bus.rs1d !== 32'h300) begin bad++; $display("FAIL hart3_r3: got %h want 00000300", bus.rs1d); end
    rd(2'd1, 5'd31, 5'd3);
    total++; if (bus.rs1d !== 32'hCAFE_0031) begin bad++; $display("FAIL hart1_r31: got %h want cafe0031", bus.rs1d); end
    total++; if (bus.rs2d !== 32'h0) begin bad++; $display("FAIL hart1_r3: got %h want 0", bus.rs2d); end
  endtask

  task automatic test_hazard();
    wb(2'd0, 5'd7, T5_WB_ALU, 32'h11, 32'h0, 32'h0);
    bus.sena = 1'b1; bus.mwre = 1'b1; bus.mhart = 2'd0; bus.rd0a = 5'd7; bus.msel = T5_WB_ALU;
    bus.malu = 32'h22; bus.fhart = 2'd0; bus.rs1a = 5'd7; bus.rs2a = 5'd5;
    step();
    bus.mwre = 1'b0;
    $display("write+read hart=0 r7 rs1d=%h rs2d=%h", bus.rs1d, bus.rs2d);
    total++; if (bus.rs1d !== HZ_EXP) begin bad++; $display("FAIL hazard_rs1: got %h want %h", bus.rs1d, HZ_EXP); end
    total++; if (bus.rs2d !== 32'h0) begin bad++; $display("FAIL hazard_rs2: got %h want 0", bus.rs2d); end
    rd(2'd0, 5'd7, 5'd7);
    total++; if (bus.rs2d !== 32'h22) begin bad++; $display("FAIL hazard_after: got %h want 00000022", bus.rs2d); end
  endtask

  task automatic test_stall();
    rd(2'd0, 5'd7, 5'd3);
    bus.sena = 1'b0; bus.mwre = 1'b1; bus.mhart = 2'd0; bus.rd0a = 5'd7; bus.msel = T5_WB_ALU;
    bus.malu = 32'h77; bus.fhart = 2'd3; bus.rs1a = 5'd3; bus.rs2a = 5'd3;
    repeat (3) step();
    bus.mwre = 1'b0;
    $display("stall 3 cycles rs1d=%h rs2d=%h", bus.rs1d, bus.rs2d);
    total++; if (bus.rs1d !== 32'h22) begin bad++; $display("FAIL stall_hold_rs1: got %h want 00000022", bus.rs1d); end
    total++; if (bus.rs2d !== 32'h100) begin bad++; $display("FAIL stall_hold_rs2: got %h want 00000100", bus.rs2d); end
    rd(2'd0, 5'd7, 5'd7);
    total++; if (bus.rs1d !== 32'h22) begin bad++; $display("FAIL stall_no_write: got %h want 00000022", bus.rs1d); end
    wb(2'd0, 5'd7, T5_WB_ALU, 32'h77, 32'h0, 32'h0);
    rd(2'd0, 5'd7, 5'd3);
    total++; if (bus.rs1d !== 32'h77) begin bad++; $display("FAIL stall_resume: got %h want 00000077", bus.rs1d); end
  endtask

  task automatic test_mid_reset();
    int cnt;
    int early;
    rst_n = 1'b0;
    #1;
    $display("async reset asserted busy=%0b rs1d=%h", bus.busy, bus.rs1d);
    total++; if (bus.rs1d !== 32'h0) begin bad++; $display("FAIL async_rst_rs1d: got %h want 0", bus.rs1d); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL async_rst_busy: got %b want 1", bus.busy); end
    step();
    rst_n = 1'b1;
    early = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.busy !== 1'b1) early++;
    end
    total++; if (early != 0) begin bad++; $display("FAIL sweep_early_done: got %0d want 0", early); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL midsweep_rst_busy: got %b want 1", bus.busy); end
    step();
    rst_n = 1'b1;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 400) begin
      step();
      cnt++;
    end
    $display("restarted sweep done after %0d cycles", cnt);
    total++; if (cnt != 128) begin bad++; $display("FAIL restart_len: got %0d want 128", cnt); end
    rd(2'd0, 5'd7, 5'd3);
    total++; if (bus.rs1d !== 32'h0) begin bad++; $display("FAIL cleared_h0r7: got %h want 0", bus.rs1d); end
    rd(2'd2, 5'd10, 5'd11);
    total++; if (bus.rs1d !== 32'h0 || bus.rs2d !== 32'h0) begin
      bad++; $display("FAIL cleared_h2: got %h/%h want 0/0", bus.rs1d, bus.rs2d);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_x0_src();
    test_harts();
    test_hazard();
    test_stall();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/t5_regs_mt.md
Name: t5_regs_mt

Overview:
- Parametrised next-generation register block for the T5 multi-hart core.
- Holds one 32-entry GPR bank per hart, with 2 synchronous read ports and 1 write-back port.
- Selects write-back data internally from ALU, data-bus or PC sources.
- After reset, a sweep state machine zeroes the whole array, so no hart ever reads stale contents.
- Sits between fetch/decode (read side) and memory stage (write side).

Parameters:
- XLEN, 32, data width in bits.
- HW, 2, hart-index width; NHART = 2**HW banks.
- NREG, 32, registers per hart; power of two, 2..32.

Ports:
- sclk  in  1  core clock, all state on rising edge.
- srstn  in  1  asynchronous, active-low reset.
- sena  in  1  pipeline advance enable.
- fhart  in  HW  hart issuing reads.
- rs1a  in  5  read address, port 1.
- rs2a  in  5  read address, port 2.
- rs1d  out  XLEN  read data, port 1.
- rs2d  out  XLEN  read data, port 2.
- mhart  in  HW  hart of write-back.
- mwre  in  1  write-back request.
- msel  in  2  write-back source: 0 = malu, 1 = dwb_dti, 2 = mpc, 3 = zero.
- rd0a  in  5  write-back register address.
- malu  in  XLEN  ALU result.
- dwb_dti  in  XLEN  load data.
- mpc  in  XLEN  link address.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (srstn=0): rs1d=0, rs2d=0, busy=1, FSM=CLR, sweep index=0. Takes effect immediately, including mid-sweep or mid-operation.
- FSM state CLR:
  - Each cycle, write zero to flat entry {hart,idx}, then increment the index.
  - The sweep is independent of sena.
  - After index NHART*NREG-1 is written, go to RUN next cycle and drop busy to 0.
  - Sweep length is exactly NHART*NREG cycles (128 at defaults).
- In CLR: mwre is ignored (dropped, not queued); rs1d/rs2d are held at 0.
- In RUN, reads:
  - On a sclk edge with sena=1: rs1d <= bank[fhart][rs1a], rs2d <= bank[fhart][rs2a]. Latency is 1 cycle.
  - sena=0: read outputs hold.
- In RUN, writes:
  - On a sclk edge with sena=1, mwre=1 and rd0a!=0: bank[mhart][rd0a] <= mux(msel).
  - Writes to rd0a=0 are discarded. Register 0 always reads 0, for every hart.
- Address width: only the low log2(NREG) bits of the addresses are used. If NREG<32 and an address bit above that is set, the read returns 0 and the write is discarded.
- Simultaneous read and write of the same hart/register in the same cycle: the read returns the OLD value unless T5_REGS_BYPASS_EN is defined.
- Writes to different harts never interfere.
- The internal cmp/mux logic has no combinational path from inputs to rs1d/rs2d.

Optional Feature:
- T5_REGS_BYPASS_EN defined:
  - If mwre=1, sena=1, mhart==fhart, rd0a==rsNa and rd0a!=0, rsNd captures the write-back mux value in the same edge (write-first).
  - Applies to each port independently.
- Undefined: read-first behaviour as above. The pipeline's external forwarding covers the hazard.

Decomposition:
- Shared package t5_pkg:
  - XLEN default.
  - msel encodings: T5_WB_ALU, T5_WB_DWB, T5_WB_PC, T5_WB_ZERO.
  - FSM state encoding: CLR=1'b0, RUN=1'b1.
- Sub-module t5_gprf_ram:
  - Flat NHART*NREG x XLEN storage with 2 synchronous read ports and 1 write port, no reset on the array.
  - t5_regs_mt owns the sweep FSM, write-back mux, x0 masking and optional bypass.

Test Plan:
- Reset sweep: release srstn, hold mwre=1 -> busy=1 for exactly 128 cycles, then 0; any register reads 0x00000000 afterwards.
- Basic write/read: hart 2, msel=0, malu=0xDEADBEEF, rd0a=5; next cycle fhart=2, rs1a=5 -> rs1d=0xDEADBEEF one cycle later; hart 1 r5 reads 0.
- x0 and source select: write rd0a=0 with malu=0x1234 -> reads 0. msel=1 with dwb_dti=0xA5A5A5A5, and msel=2 with mpc=0x00000104, each to distinct registers -> each reads back its source value.
- Same-cycle hazard: write hart 0 r7 = 0x11 then r7 = 0x22, reading r7 in the second write cycle -> rs1d=0x11 without the macro, 0x22 with T5_REGS_BYPASS_EN.
- sena stall: sena=0 with mwre=1 -> no write, rs1d/rs2d hold their values; raise sena -> behaviour resumes.
- Reset mid-sweep at cycle 40 -> busy stays 1 and the sweep restarts, completing 128 cycles after the new release.
